// File: rtl/othello_pkg.sv
// othello_pkg: shared Othello definitions.
//   Cell codes, board geometry, move_flipper state enum, and the eight
//   ray offsets in their fixed scan order (NW, N, NE, W, E, SW, S, SE).
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_P1     = 2'b01;
    localparam logic [1:0] CELL_P2     = 2'b10;
    localparam logic [1:0] CELL_BORDER = 2'b11;

    localparam int BOARD_CELLS = 100;
    localparam int BOARD_W     = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK_RD,
        ST_CHK_EV,
        ST_DIR_INIT,
        ST_STEP_RD,
        ST_STEP_EV,
        ST_FLIP_WR,
        ST_NEXT_DIR,
        ST_PLACE,
        ST_DONE
    } flip_state_t;

    localparam logic signed [6:0] DIR_OFFSETS [8] = '{
        -7'sd11, -7'sd10, -7'sd9, -7'sd1, 7'sd1, 7'sd9, 7'sd10, 7'sd11
    };

    // A request is rejected without touching RAM when the mover code is not a
    // player or the target lies outside the board.
    function automatic logic request_valid(input logic [6:0] pos, input logic [1:0] player);
        return (player == CELL_P1 || player == CELL_P2) && (pos < 7'(BOARD_CELLS));
    endfunction

endpackage

// File: rtl/dir_offset_lut.sv
// dir_offset_lut: maps a ray index to its 7-bit two's-complement cell offset.
//   d    in  3  ray index 0..7
//   off  out 7  address offset, added modulo 128
module dir_offset_lut
    import othello_pkg::*;
(
    input  logic [2:0] d,
    output logic [6:0] off
);

    assign off = DIR_OFFSETS[d];

endmodule

// File: rtl/move_flipper.sv
// move_flipper: executes one Othello move on the shared 10x10 board RAM.
//   clock, reset      single clock, synchronous active-high reset
//   start/pos/player  move request, accepted only in IDLE
//   q                 RAM read data, one cycle after addr
//   busy, ctrl_mem    high while the move owns the RAM
//   done              one-cycle completion pulse
//   legal, flips      result, held until the next accepted start
//   addr/data/wren    RAM access
// Optional: MOVE_FLIPPER_DRYRUN_EN adds input dry_run; when latched high the
// move is evaluated fully but never written.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start
// CHK_RD    | reading target cell
// CHK_EV    | target must be empty
// DIR_INIT  | first cell of ray d
// STEP_RD   | reading cell cur of ray d
// STEP_EV   | extend opponent run / bracket found / ray dead
// FLIP_WR   | writing player over the bracketed run
// NEXT_DIR  | advance ray, or place / finish after ray 7
// PLACE     | write player at target, mark legal
// DONE      | raise done, return to IDLE
module move_flipper
    import othello_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] pos,
    input  logic [1:0] player,
    input  logic [1:0] q,
    output logic       busy,
    output logic       done,
    output logic       legal,
    output logic [4:0] flips,
    output logic       ctrl_mem,
    output logic [6:0] addr,
    output logic [1:0] data,
    output logic       wren
`ifdef MOVE_FLIPPER_DRYRUN_EN
    ,
    input  logic       dry_run
`endif
);

    flip_state_t state;
    logic [6:0]  pos_r;
    logic [1:0]  player_r;
    logic        dry_r;
    logic [2:0]  d;
    logic [6:0]  cur;
    logic [3:0]  run;
    logic [6:0]  off;
    logic        dry_in;

`ifdef MOVE_FLIPPER_DRYRUN_EN
    assign dry_in = dry_run;
`else
    assign dry_in = 1'b0;
`endif

    dir_offset_lut u_dir_offset_lut (
        .d   (d),
        .off (off)
    );

    logic [6:0] first_cell;
    logic [6:0] next_cell;
    logic [1:0] wr_data;

    assign first_cell = pos_r + off;
    assign next_cell  = cur + off;
    assign wr_data    = dry_r ? CELL_EMPTY : player_r;

    // addr/data/wren are registered, so they are loaded on the transition
    // into the state that uses them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            pos_r    <= '0;
            player_r <= '0;
            dry_r    <= 1'b0;
            d        <= '0;
            cur      <= '0;
            run      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            legal    <= 1'b0;
            flips    <= '0;
            ctrl_mem <= 1'b0;
            addr     <= '0;
            data     <= '0;
            wren     <= 1'b0;
        end else begin
            done <= 1'b0;
            wren <= 1'b0;
            data <= CELL_EMPTY;
            addr <= '0;
            case (state)
                ST_IDLE: begin
                    busy     <= 1'b0;
                    ctrl_mem <= 1'b0;
                    if (start) begin
                        pos_r    <= pos;
                        player_r <= player;
                        dry_r    <= dry_in;
                        legal    <= 1'b0;
                        flips    <= '0;
                        busy     <= 1'b1;
                        ctrl_mem <= 1'b1;
                        if (request_valid(pos, player)) begin
                            addr  <= pos;
                            state <= ST_CHK_RD;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CHK_RD: state <= ST_CHK_EV;
                ST_CHK_EV: begin
                    if (q != CELL_EMPTY) begin
                        state <= ST_DONE;
                    end else begin
                        d     <= '0;
                        state <= ST_DIR_INIT;
                    end
                end
                ST_DIR_INIT: begin
                    cur   <= first_cell;
                    run   <= '0;
                    addr  <= first_cell;
                    state <= ST_STEP_RD;
                end
                ST_STEP_RD: state <= ST_STEP_EV;
                ST_STEP_EV: begin
                    if (q == (player_r ^ 2'b11)) begin
                        run   <= run + 4'd1;
                        cur   <= next_cell;
                        addr  <= next_cell;
                        state <= ST_STEP_RD;
                    end else if (q == player_r && run != 4'd0) begin
                        // Rewind to the first cell of the ray and flip run cells.
                        cur   <= first_cell;
                        addr  <= first_cell;
                        wren  <= ~dry_r;
                        data  <= wr_data;
                        state <= ST_FLIP_WR;
                    end else begin
                        state <= ST_NEXT_DIR;
                    end
                end
                ST_FLIP_WR: begin
                    cur   <= next_cell;
                    run   <= run - 4'd1;
                    flips <= flips + 5'd1;
                    if (run > 4'd1) begin
                        addr <= next_cell;
                        wren <= ~dry_r;
                        data <= wr_data;
                    end else begin
                        state <= ST_NEXT_DIR;
                    end
                end
                ST_NEXT_DIR: begin
                    d <= d + 3'd1;
                    if (d != 3'd7) begin
                        state <= ST_DIR_INIT;
                    end else if (flips != 5'd0) begin
                        addr  <= pos_r;
                        wren  <= ~dry_r;
                        data  <= wr_data;
                        state <= ST_PLACE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_PLACE: begin
                    legal <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_flipper.sv
module tb_move_flipper;
    import othello_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] pos = '0;
    logic [1:0] player = '0;
    logic [1:0] q;
    logic       busy, done, legal, ctrl_mem, wren;
    logic [4:0] flips;
    logic [6:0] addr;
    logic [1:0] data;
`ifdef MOVE_FLIPPER_DRYRUN_EN
    logic       dry_run = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [1:0] mem [100];
    logic [1:0] exp_mem [100];
    int  wren_cnt = 0;
    int  done_cnt = 0;
    bit  addr_seen = 0;

    always #5 clock = ~clock;

    move_flipper dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pos      (pos),
        .player   (player),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .legal    (legal),
        .flips    (flips),
        .ctrl_mem (ctrl_mem),
        .addr     (addr),
        .data     (data),
        .wren     (wren)
`ifdef MOVE_FLIPPER_DRYRUN_EN
        ,
        .dry_run  (dry_run)
`endif
    );

    // Board RAM: synchronous read, one cycle latency.
    always @(posedge clock) begin
        q <= (addr < 7'd100) ? mem[addr] : CELL_BORDER;
        if (wren && addr < 7'd100) mem[addr] = data;
    end

    always @(negedge clock) begin
        if (wren) wren_cnt++;
        if (done) done_cnt++;
        if (addr != 7'd0) addr_seen = 1;
    end

    task automatic clear_board();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                mem[r*10+c] = (r == 0 || r == 9 || c == 0 || c == 9) ? CELL_BORDER : CELL_EMPTY;
    endtask

    task automatic init_board();
        clear_board();
        mem[44] = CELL_P1; mem[55] = CELL_P1;
        mem[45] = CELL_P2; mem[54] = CELL_P2;
    endtask

    task automatic preload_multi();
        clear_board();
        mem[45] = CELL_P2; mem[46] = CELL_P2; mem[47] = CELL_P1;
        mem[54] = CELL_P2; mem[64] = CELL_P1;
        mem[55] = CELL_P2; mem[66] = CELL_P2; mem[77] = CELL_P2; mem[88] = CELL_P1;
    endtask

    task automatic snap_expected();
        for (int i = 0; i < 100; i++) exp_mem[i] = mem[i];
    endtask

    function automatic int board_diffs();
        int nd = 0;
        for (int i = 0; i < 100; i++) if (mem[i] !== exp_mem[i]) nd++;
        return nd;
    endfunction

    // n = cycle after the start edge in which done is first visible.
    task automatic do_move(input logic [6:0] p, input logic [1:0] pl, output int n, output logic busy_first);
        @(negedge clock);
        pos = p; player = pl; start = 1'b1;
        wren_cnt = 0; done_cnt = 0; addr_seen = 0;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        busy_first = busy;
        while (!done && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL move_timeout pos=%0d: done not seen in %0d cycles", p, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, done, legal, ctrl_mem, wren, flips, addr, data} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b legal=%b ctrl=%b wren=%b flips=%0d addr=%0d data=%b, want all 0",
                     busy, done, legal, ctrl_mem, wren, flips, addr, data);
        end
        reset = 1'b0;
    endtask

    task automatic test_simple_flip();
        int n; logic bf;
        init_board();
        do_move(7'd46, CELL_P1, n, bf);
        n_checks++;
        if (bf !== 1'b1) begin n_fail++; $display("FAIL simple_busy: got %b want 1", bf); end
        n_checks++;
        if (legal !== 1'b1 || flips !== 5'd1) begin
            n_fail++; $display("FAIL simple_result: got legal=%b flips=%0d want legal=1 flips=1", legal, flips);
        end
        n_checks++;
        if (mem[45] !== CELL_P1 || mem[46] !== CELL_P1) begin
            n_fail++; $display("FAIL simple_board: got m45=%b m46=%b want 01 01", mem[45], mem[46]);
        end
        n_checks++;
        if (wren_cnt != 2) begin n_fail++; $display("FAIL simple_wren_cycles: got %0d want 2", wren_cnt); end
        repeat (3) @(negedge clock);
        n_checks++;
        if (legal !== 1'b1 || flips !== 5'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL simple_hold: got legal=%b flips=%0d busy=%b want 1 1 0", legal, flips, busy);
        end
    endtask

    task automatic test_occupied();
        int n; logic bf;
        init_board();
        do_move(7'd44, CELL_P1, n, bf);
        n_checks++;
        if (n != 4) begin n_fail++; $display("FAIL occupied_latency: got %0d want 4", n); end
        n_checks++;
        if (legal !== 1'b0 || flips !== 5'd0 || wren_cnt != 0) begin
            n_fail++; $display("FAIL occupied_result: got legal=%b flips=%0d wren=%0d want 0 0 0", legal, flips, wren_cnt);
        end
    endtask

    task automatic test_illegal();
        int n; logic bf;
        init_board(); snap_expected();
        do_move(7'd33, CELL_P1, n, bf);
        n_checks++;
        if (legal !== 1'b0 || wren_cnt != 0 || board_diffs() != 0) begin
            n_fail++; $display("FAIL no_bracket: got legal=%b wren=%0d diffs=%0d want 0 0 0", legal, wren_cnt, board_diffs());
        end
        do_move(7'd0, CELL_P1, n, bf);
        n_checks++;
        if (legal !== 1'b0 || wren_cnt != 0 || n != 4) begin
            n_fail++; $display("FAIL border_target: got legal=%b wren=%0d n=%0d want 0 0 4", legal, wren_cnt, n);
        end
        do_move(7'd120, CELL_P1, n, bf);
        n_checks++;
        if (n != 2 || wren_cnt != 0 || addr_seen || legal !== 1'b0) begin
            n_fail++; $display("FAIL pos_range_reject: got n=%0d wren=%0d addr_seen=%b legal=%b want 2 0 0 0", n, wren_cnt, addr_seen, legal);
        end
        do_move(7'd46, 2'b11, n, bf);
        n_checks++;
        if (n != 2 || wren_cnt != 0 || addr_seen) begin
            n_fail++; $display("FAIL player_reject: got n=%0d wren=%0d addr_seen=%b want 2 0 0", n, wren_cnt, addr_seen);
        end
    endtask

    task automatic test_multi_dir();
        int n; logic bf;
        preload_multi(); snap_expected();
        exp_mem[44] = CELL_P1; exp_mem[45] = CELL_P1; exp_mem[46] = CELL_P1;
        exp_mem[54] = CELL_P1; exp_mem[55] = CELL_P1; exp_mem[66] = CELL_P1; exp_mem[77] = CELL_P1;
        do_move(7'd44, CELL_P1, n, bf);
        n_checks++;
        if (legal !== 1'b1 || flips !== 5'd6) begin
            n_fail++; $display("FAIL multi_result: got legal=%b flips=%0d want 1 6", legal, flips);
        end
        n_checks++;
        if (board_diffs() != 0) begin n_fail++; $display("FAIL multi_board: got %0d differing cells want 0", board_diffs()); end
        n_checks++;
        if (wren_cnt != 7 || n > 200) begin
            n_fail++; $display("FAIL multi_wren_latency: got wren=%0d n=%0d want 7 and <=200", wren_cnt, n);
        end
    endtask

    task automatic test_back_to_back();
        init_board();
        @(negedge clock);
        pos = 7'd46; player = CELL_P1; start = 1'b1; done_cnt = 0;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        pos = 7'd33; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (120) @(negedge clock);
        n_checks++;
        if (done_cnt != 1 || flips !== 5'd1 || legal !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_ignored: got dones=%0d flips=%0d legal=%b want 1 1 1", done_cnt, flips, legal);
        end
    endtask

    task automatic test_reset_mid_move();
        int k;
        preload_multi();
        @(negedge clock);
        pos = 7'd44; player = CELL_P1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!wren && k < 200) begin @(negedge clock); k++; end
        n_checks++;
        if (!wren) begin n_fail++; $display("FAIL midmove_no_write: got wren=0 after %0d cycles want 1", k); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (wren !== 1'b0 || busy !== 1'b0 || ctrl_mem !== 1'b0 || flips !== 5'd0 || dut.state !== ST_IDLE) begin
            n_fail++; $display("FAIL midmove_reset: got wren=%b busy=%b ctrl=%b flips=%0d idle=%b want 0 0 0 0 1",
                               wren, busy, ctrl_mem, flips, dut.state == ST_IDLE);
        end
        n_checks++;
        if (mem[45] !== CELL_P1 || mem[46] !== CELL_P2 || mem[44] !== CELL_EMPTY) begin
            n_fail++; $display("FAIL midmove_partial: got m44=%b m45=%b m46=%b want 00 01 10", mem[44], mem[45], mem[46]);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

`ifdef MOVE_FLIPPER_DRYRUN_EN
    task automatic test_dry_run();
        int n; logic bf;
        init_board(); snap_expected();
        dry_run = 1'b1;
        do_move(7'd35, CELL_P1, n, bf);
        dry_run = 1'b0;
        n_checks++;
        if (legal !== 1'b1 || flips !== 5'd1 || wren_cnt != 0 || board_diffs() != 0) begin
            n_fail++; $display("FAIL dry_run: got legal=%b flips=%0d wren=%0d diffs=%0d want 1 1 0 0",
                               legal, flips, wren_cnt, board_diffs());
        end
    endtask
`endif

    initial begin
        clear_board();
        test_reset();
        test_simple_flip();
        test_occupied();
        test_illegal();
        test_multi_dir();
        test_back_to_back();
        test_reset_mid_move();
`ifdef MOVE_FLIPPER_DRYRUN_EN
        test_dry_run();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
